uart_tx: RTL

Serial transmitter stage directly downstream of the UART register bank. Consumes the bank's transmit enable, CRC enable, 16-bit clock divider, one-cycle start command and 8-bit data byte. Drives the serial line with an 8N1 frame and, when CRC is active, a trailing CRC-8 frame. Reports busy and completion status back to the register bank.

---
 rtl/uart_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with optional trailing CRC-8 frame
//
// Ports:
//   clk             : system clock, rising edge
//   rst_i           : synchronous active-high reset
//   tx_en_i         : transmitter enable; low aborts to idle
//   crc_en_i        : append CRC-8 frame after data frame (sampled at start)
//   clock_divider_i : bit period = clock_divider_i + 1 clk cycles (sampled at start)
//   tx_start_cmd_i  : one-cycle start pulse
//   tx_data_i       : byte to send (sampled at start)
//   tx_o            : registered serial line, idle high
//   busy_o          : high while a transmission is in progress
//   done_o          : one-cycle pulse in the last cycle of the final stop bit
//
// Configuration macro: UART_TX_CRC_EN compiles in the CRC frame logic;
// without it crc_en_i is ignored and every transmission is one data frame.

module uart_tx (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        tx_en_i,
    input  logic        crc_en_i,
    input  logic [15:0] clock_divider_i,
    input  logic        tx_start_cmd_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        bit_end;
    logic        crc_next_frame;

`ifdef UART_TX_CRC_EN
    logic       crc_en_q, crc_en_d;
    logic       crc_phase_q, crc_phase_d;
    logic [7:0] data_q, data_d;
    logic [7:0] crc_byte;

    // CRC-8, poly 0x07, init 0, no reflection, no final xor, over the latched byte.
    always_comb begin
        crc_byte = data_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_byte[7])
                crc_byte = {crc_byte[6:0], 1'b0} ^ 8'h07;
            else
                crc_byte = {crc_byte[6:0], 1'b0};
        end
    end

    assign crc_next_frame = crc_en_q & ~crc_phase_q;
`else
    logic unused_crc_en;
    assign unused_crc_en  = crc_en_i;
    assign crc_next_frame = 1'b0;
`endif

    // The current bit period ends in the cycle the down-counter reads zero.
    assign bit_end = (timer_q == 16'd0);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        timer_d = timer_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        done_o  = 1'b0;
`ifdef UART_TX_CRC_EN
        crc_en_d    = crc_en_q;
        crc_phase_d = crc_phase_q;
        data_d      = data_q;
`endif
        if (!tx_en_i) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            timer_d = 16'd0;
            bit_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (tx_start_cmd_i) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        div_d   = clock_divider_i;
                        timer_d = clock_divider_i;
                        shift_d = tx_data_i;
                        bit_d   = 3'd0;
`ifdef UART_TX_CRC_EN
                        crc_en_d    = crc_en_i;
                        crc_phase_d = 1'b0;
                        data_d      = tx_data_i;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_d = DATA;
                        tx_d    = shift_q[0];
                        timer_d = div_q;
                        bit_d   = 3'd0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_d = div_q;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            // tx is registered, so present the next bit from shift_q[1].
                            shift_d = {1'b0, shift_q[7:1]};
                            tx_d    = shift_q[1];
                            bit_d   = bit_q + 3'd1;
                        end
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (crc_next_frame) begin
                            // Chain straight into the CRC frame with no idle gap.
                            state_d = START;
                            tx_d    = 1'b0;
                            timer_d = div_q;
`ifdef UART_TX_CRC_EN
                            crc_phase_d = 1'b1;
                            shift_d     = crc_byte;
`endif
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            done_o  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= 16'd0;
            timer_q <= 16'd0;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
`ifdef UART_TX_CRC_EN
            crc_en_q    <= 1'b0;
            crc_phase_q <= 1'b0;
            data_q      <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
`ifdef UART_TX_CRC_EN
            crc_en_q    <= crc_en_d;
            crc_phase_q <= crc_phase_d;
            data_q      <= data_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE);

endmodule
